// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address width, register count and the
// write-port grant encoding used by the arbiter.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_CSR,
    GNT_MDU
  } grant_e;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy bits for registers awaiting an MDU result, with two query ports that
// see through a same-cycle MDU write to the queried register.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_set,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_1,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_2,
  output logic                  o_busy_1,
  output logic                  o_busy_2
);
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-cycle issue keeps the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (i_clr) busy_d[i_clr_addr] = 1'b0;
    if (i_set) busy_d[i_set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     busy_q <= '0;
    else if (i_en) busy_q <= busy_d;
  end

  assign o_busy_1 = !i_rst && (i_rd_addr_1 != '0) && busy_q[i_rd_addr_1]
                    && !(i_clr && (i_clr_addr == i_rd_addr_1));
  assign o_busy_2 = !i_rst && (i_rd_addr_2 != '0) && busy_q[i_rd_addr_2]
                    && !(i_clr && (i_clr_addr == i_rd_addr_2));
endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter for WB, CSR and MDU writers, with an MDU
// starvation override and a busy scoreboard for decode RAW stalls.
module reg_write_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clk_enable,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]       i_wb_data,
  input  logic                  i_csr_valid,
  input  logic [REG_ADDR_W-1:0] i_csr_addr,
  input  logic [XLEN-1:0]       i_csr_data,
  output logic                  o_csr_ready,
  input  logic                  i_mdu_valid,
  input  logic [REG_ADDR_W-1:0] i_mdu_addr,
  input  logic [XLEN-1:0]       i_mdu_data,
  output logic                  o_mdu_ready,
  input  logic                  i_mdu_issue,
  input  logic [REG_ADDR_W-1:0] i_mdu_issue_addr,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_1,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_2,
  output logic                  o_busy_1,
  output logic                  o_busy_2,
  output logic                  o_wb_stall,
  output logic                  o_reg_write,
  output logic [REG_ADDR_W-1:0] o_wr_addr,
  output logic [XLEN-1:0]       o_wr_data
);
  localparam int                CNT_W = 4;
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             active;
  logic             starved;
  logic             mdu_gnt;
  grant_e           gnt;

  assign active  = !i_rst && i_clk_enable;
  assign starved = (starve_q == LIMIT);

  always_comb begin
    gnt = GNT_NONE;
    if (active) begin
      if (starved && i_mdu_valid) gnt = GNT_MDU;
      else if (i_wb_valid)        gnt = GNT_WB;
      else if (i_csr_valid)       gnt = GNT_CSR;
      else if (i_mdu_valid)       gnt = GNT_MDU;
    end
  end

  assign mdu_gnt     = (gnt == GNT_MDU);
  assign o_csr_ready = (gnt == GNT_CSR);
  assign o_mdu_ready = mdu_gnt;
  assign o_wb_stall  = active && i_wb_valid && (gnt != GNT_WB);

  always_comb begin
    o_wr_addr = '0;
    o_wr_data = '0;
    case (gnt)
      GNT_WB:  begin o_wr_addr = i_wb_addr;  o_wr_data = i_wb_data;  end
      GNT_CSR: begin o_wr_addr = i_csr_addr; o_wr_data = i_csr_data; end
      GNT_MDU: begin o_wr_addr = i_mdu_addr; o_wr_data = i_mdu_data; end
      default: begin o_wr_addr = '0;         o_wr_data = '0;         end
    endcase
  end

  // x0 writes still complete the handshake but never reach the register file.
  assign o_reg_write = (gnt != GNT_NONE) && (o_wr_addr != '0);

  always_comb begin
    starve_d = starve_q;
    if (!i_mdu_valid || mdu_gnt) starve_d = '0;
    else if (starve_q != LIMIT)  starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)             starve_q <= '0;
    else if (i_clk_enable) starve_q <= starve_d;
  end

  reg_scoreboard u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_clk_enable),
    .i_set       (i_mdu_issue),
    .i_set_addr  (i_mdu_issue_addr),
    .i_clr       (mdu_gnt),
    .i_clr_addr  (i_mdu_addr),
    .i_rd_addr_1 (i_rd_addr_1),
    .i_rd_addr_2 (i_rd_addr_2),
    .o_busy_1    (o_busy_1),
    .o_busy_2    (o_busy_2)
  );
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level reference
// model of the write-port arbiter.
module tb_reg_write_arbiter;
  localparam int XLEN = 32;
  localparam int LIM  = 4;

  logic            i_clk = 1'b0;
  logic            i_rst, i_clk_enable;
  logic            i_wb_valid, i_csr_valid, i_mdu_valid, i_mdu_issue;
  logic [4:0]      i_wb_addr, i_csr_addr, i_mdu_addr, i_mdu_issue_addr;
  logic [4:0]      i_rd_addr_1, i_rd_addr_2;
  logic [XLEN-1:0] i_wb_data, i_csr_data, i_mdu_data;
  logic            o_csr_ready, o_mdu_ready, o_busy_1, o_busy_2;
  logic            o_wb_stall, o_reg_write;
  logic [4:0]      o_wr_addr;
  logic [XLEN-1:0] o_wr_data;

  int checks   = 0;
  int failures = 0;

  bit [31:0] m_busy;
  int        m_cnt;

  always #5 i_clk = ~i_clk;

  reg_write_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_enable(i_clk_enable),
    .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_csr_valid(i_csr_valid), .i_csr_addr(i_csr_addr), .i_csr_data(i_csr_data),
    .o_csr_ready(o_csr_ready),
    .i_mdu_valid(i_mdu_valid), .i_mdu_addr(i_mdu_addr), .i_mdu_data(i_mdu_data),
    .o_mdu_ready(o_mdu_ready),
    .i_mdu_issue(i_mdu_issue), .i_mdu_issue_addr(i_mdu_issue_addr),
    .i_rd_addr_1(i_rd_addr_1), .i_rd_addr_2(i_rd_addr_2),
    .o_busy_1(o_busy_1), .o_busy_2(o_busy_2),
    .o_wb_stall(o_wb_stall), .o_reg_write(o_reg_write),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_wb_valid = 0; i_wb_addr = 0; i_wb_data = 0;
    i_csr_valid = 0; i_csr_addr = 0; i_csr_data = 0;
    i_mdu_valid = 0; i_mdu_addr = 0; i_mdu_data = 0;
    i_mdu_issue = 0; i_mdu_issue_addr = 0;
  endtask

  task automatic test_reset();
    i_rst = 1; i_clk_enable = 1;
    i_wb_valid = 1; i_wb_addr = 5'd1; i_wb_data = 32'h11;
    i_csr_valid = 1; i_csr_addr = 5'd2; i_csr_data = 32'h22;
    i_mdu_valid = 1; i_mdu_addr = 5'd3; i_mdu_data = 32'h33;
    i_mdu_issue = 1; i_mdu_issue_addr = 5'd3;
    i_rd_addr_1 = 5'd3; i_rd_addr_2 = 5'd7;
    tick();
    #1;
    checks++; if (o_reg_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", o_reg_write); end
    checks++; if (o_csr_ready !== 1'b0 || o_mdu_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b%b exp=00", o_csr_ready, o_mdu_ready); end
    tick();
    i_rst = 0; idle();
    #1;
    checks++; if (o_busy_1 !== 1'b0 || o_busy_2 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b%b exp=00", o_busy_1, o_busy_2); end
    tick();
  endtask

  task automatic test_priority();
    i_wb_valid = 1; i_wb_addr = 5'd5; i_wb_data = 32'hA;
    i_csr_valid = 1; i_csr_addr = 5'd6; i_csr_data = 32'hB;
    i_mdu_valid = 1; i_mdu_addr = 5'd7; i_mdu_data = 32'hC;
    #1;
    checks++; if (o_reg_write !== 1'b1 || o_wr_addr !== 5'd5 || o_wr_data !== 32'hA || o_csr_ready !== 1'b0 || o_mdu_ready !== 1'b0)
      begin failures++; $display("FAIL prio_c1 got=%b/%0d/%h/%b%b exp=1/5/a/00", o_reg_write, o_wr_addr, o_wr_data, o_csr_ready, o_mdu_ready); end
    tick(); i_wb_valid = 0; #1;
    checks++; if (o_reg_write !== 1'b1 || o_wr_addr !== 5'd6 || o_wr_data !== 32'hB || o_csr_ready !== 1'b1 || o_mdu_ready !== 1'b0)
      begin failures++; $display("FAIL prio_c2 got=%b/%0d/%h/%b%b exp=1/6/b/10", o_reg_write, o_wr_addr, o_wr_data, o_csr_ready, o_mdu_ready); end
    tick(); i_csr_valid = 0; #1;
    checks++; if (o_reg_write !== 1'b1 || o_wr_addr !== 5'd7 || o_wr_data !== 32'hC || o_mdu_ready !== 1'b1)
      begin failures++; $display("FAIL prio_c3 got=%b/%0d/%h/%b exp=1/7/c/1", o_reg_write, o_wr_addr, o_wr_data, o_mdu_ready); end
    tick(); idle();
  endtask

  task automatic test_starvation();
    i_wb_valid = 1; i_wb_addr = 5'd1; i_wb_data = 32'h100;
    i_mdu_valid = 1; i_mdu_addr = 5'd9; i_mdu_data = 32'h99;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c <= LIM) begin
        checks++; if (o_mdu_ready !== 1'b0 || o_wb_stall !== 1'b0 || o_wr_addr !== 5'd1)
          begin failures++; $display("FAIL starve_deny c=%0d got=%b%b/%0d exp=00/1", c, o_mdu_ready, o_wb_stall, o_wr_addr); end
      end else if (c == LIM + 1) begin
        checks++; if (o_mdu_ready !== 1'b1 || o_wb_stall !== 1'b1 || o_wr_addr !== 5'd9 || o_wr_data !== 32'h99 || o_reg_write !== 1'b1)
          begin failures++; $display("FAIL starve_force got=%b%b/%0d/%h exp=11/9/99", o_mdu_ready, o_wb_stall, o_wr_addr, o_wr_data); end
      end else begin
        checks++; if (o_wb_stall !== 1'b0 || o_wr_addr !== 5'd1 || o_reg_write !== 1'b1)
          begin failures++; $display("FAIL starve_resume got=%b/%0d exp=0/1", o_wb_stall, o_wr_addr); end
      end
      tick();
      if (c == LIM + 1) i_mdu_valid = 0;
      i_wb_data = i_wb_data + 1;
    end
    idle();
  endtask

  task automatic test_scoreboard();
    i_rd_addr_1 = 5'd3;
    i_mdu_issue = 1; i_mdu_issue_addr = 5'd3;
    tick(); i_mdu_issue = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (o_busy_1 !== 1'b1) begin failures++; $display("FAIL sb_busy c=%0d got=%b exp=1", c, o_busy_1); end
      tick();
    end
    i_mdu_valid = 1; i_mdu_addr = 5'd3; i_mdu_data = 32'h3333;
    #1;
    checks++; if (o_busy_1 !== 1'b0 || o_mdu_ready !== 1'b1)
      begin failures++; $display("FAIL sb_bypass got=%b%b exp=01", o_busy_1, o_mdu_ready); end
    tick(); idle(); #1;
    checks++; if (o_busy_1 !== 1'b0) begin failures++; $display("FAIL sb_cleared got=%b exp=0", o_busy_1); end
    tick();
  endtask

  task automatic test_same_cycle();
    i_rd_addr_2 = 5'd4;
    i_mdu_valid = 1; i_mdu_addr = 5'd4; i_mdu_data = 32'h44;
    i_mdu_issue = 1; i_mdu_issue_addr = 5'd4;
    #1;
    checks++; if (o_mdu_ready !== 1'b1) begin failures++; $display("FAIL same_grant got=%b exp=1", o_mdu_ready); end
    tick(); idle(); #1;
    checks++; if (o_busy_2 !== 1'b1) begin failures++; $display("FAIL same_setwins got=%b exp=1", o_busy_2); end
    i_mdu_valid = 1; i_mdu_addr = 5'd4; i_mdu_data = 32'h45;
    tick(); idle(); #1;
    checks++; if (o_busy_2 !== 1'b0) begin failures++; $display("FAIL same_clear got=%b exp=0", o_busy_2); end
    tick();
  endtask

  task automatic test_x0();
    i_csr_valid = 1; i_csr_addr = 5'd0; i_csr_data = 32'h55;
    #1;
    checks++; if (o_csr_ready !== 1'b1 || o_reg_write !== 1'b0)
      begin failures++; $display("FAIL x0_csr got=%b%b exp=10", o_csr_ready, o_reg_write); end
    tick(); idle();
  endtask

  task automatic test_clk_enable();
    i_wb_valid = 1; i_wb_addr = 5'd2; i_wb_data = 32'h20;
    i_mdu_valid = 1; i_mdu_addr = 5'd10; i_mdu_data = 32'hAA;
    tick(); tick();
    i_clk_enable = 0;
    i_csr_valid = 1; i_csr_addr = 5'd12; i_csr_data = 32'hCC;
    i_mdu_issue = 1; i_mdu_issue_addr = 5'd11; i_rd_addr_1 = 5'd11;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (o_reg_write !== 1'b0 || o_csr_ready !== 1'b0 || o_mdu_ready !== 1'b0 || o_wb_stall !== 1'b0)
        begin failures++; $display("FAIL cke_hold c=%0d got=%b%b%b%b exp=0000", c, o_reg_write, o_csr_ready, o_mdu_ready, o_wb_stall); end
      tick();
    end
    i_clk_enable = 1; i_csr_valid = 0; i_mdu_issue = 0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      if (c < 3) begin
        checks++; if (o_mdu_ready !== 1'b0 || o_busy_1 !== 1'b0)
          begin failures++; $display("FAIL cke_count c=%0d got=%b%b exp=00", c, o_mdu_ready, o_busy_1); end
      end else begin
        checks++; if (o_mdu_ready !== 1'b1 || o_wb_stall !== 1'b1)
          begin failures++; $display("FAIL cke_force got=%b%b exp=11", o_mdu_ready, o_wb_stall); end
      end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_random();
    bit wbp, csrp, mdup, ew, eb1, eb2;
    int g;
    logic [4:0] ea, ia;
    logic [XLEN-1:0] ed;
    wbp = 0; csrp = 0; mdup = 0;
    idle(); i_rst = 1; tick(); i_rst = 0;
    m_busy = '0; m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      if (!wbp && $urandom_range(0, 9) < 5) begin wbp = 1; i_wb_addr = 5'($urandom_range(0, 7)); i_wb_data = $urandom; end
      if (!csrp && $urandom_range(0, 9) < 3) begin csrp = 1; i_csr_addr = 5'($urandom_range(0, 7)); i_csr_data = $urandom; end
      if (!mdup && $urandom_range(0, 9) < 4) begin mdup = 1; i_mdu_addr = 5'($urandom_range(0, 7)); i_mdu_data = $urandom; end
      i_wb_valid = wbp; i_csr_valid = csrp; i_mdu_valid = mdup;
      i_clk_enable = ($urandom_range(0, 9) != 0);
      i_rst = ($urandom_range(0, 149) == 0);
      ia = 5'($urandom_range(0, 7));
      i_mdu_issue_addr = ia;
      i_mdu_issue = ($urandom_range(0, 2) == 0) && !m_busy[ia];
      i_rd_addr_1 = 5'($urandom_range(0, 7));
      i_rd_addr_2 = 5'($urandom_range(0, 7));
      assert (!(i_mdu_issue && i_mdu_issue_addr != 0 && m_busy[i_mdu_issue_addr]))
        else $error("issue to busy register x%0d", i_mdu_issue_addr);
      #1;
      g = 0;
      if (!i_rst && i_clk_enable) begin
        if (m_cnt == LIM && mdup) g = 3;
        else if (wbp)             g = 1;
        else if (csrp)            g = 2;
        else if (mdup)            g = 3;
      end
      ea = (g == 1) ? i_wb_addr : (g == 2) ? i_csr_addr : (g == 3) ? i_mdu_addr : 5'd0;
      ed = (g == 1) ? i_wb_data : (g == 2) ? i_csr_data : (g == 3) ? i_mdu_data : '0;
      ew = (g != 0) && (ea != 0);
      eb1 = !i_rst && i_rd_addr_1 != 0 && m_busy[i_rd_addr_1] && !(g == 3 && i_mdu_addr == i_rd_addr_1);
      eb2 = !i_rst && i_rd_addr_2 != 0 && m_busy[i_rd_addr_2] && !(g == 3 && i_mdu_addr == i_rd_addr_2);
      checks++; if (o_reg_write !== ew || (ew && (o_wr_addr !== ea || o_wr_data !== ed)))
        begin failures++; $display("FAIL rnd_write c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, o_reg_write, o_wr_addr, o_wr_data, ew, ea, ed); end
      checks++; if (o_csr_ready !== (g == 2) || o_mdu_ready !== (g == 3))
        begin failures++; $display("FAIL rnd_ready c=%0d got=%b%b exp=%b%b", c, o_csr_ready, o_mdu_ready, g == 2, g == 3); end
      checks++; if (o_wb_stall !== (!i_rst && i_clk_enable && wbp && g != 1))
        begin failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, o_wb_stall, !i_rst && i_clk_enable && wbp && g != 1); end
      checks++; if (o_busy_1 !== eb1 || o_busy_2 !== eb2)
        begin failures++; $display("FAIL rnd_busy c=%0d got=%b%b exp=%b%b", c, o_busy_1, o_busy_2, eb1, eb2); end
      if (i_rst) begin
        m_busy = '0; m_cnt = 0; wbp = 0; csrp = 0; mdup = 0;
      end else if (i_clk_enable) begin
        if (g == 3) m_busy[i_mdu_addr] = 1'b0;
        if (i_mdu_issue && ia != 0) m_busy[ia] = 1'b1;
        if (!mdup || g == 3) m_cnt = 0;
        else if (m_cnt < LIM) m_cnt = m_cnt + 1;
        if (g == 1) wbp = 0;
        if (g == 2) csrp = 0;
        if (g == 3) mdup = 0;
      end
      tick();
    end
    i_rst = 0; i_clk_enable = 1; idle();
  endtask

  initial begin
    idle();
    i_rst = 1; i_clk_enable = 1; i_rd_addr_1 = 0; i_rd_addr_2 = 0;
    tick();
    test_reset();
    test_priority();
    test_starvation();
    test_scoreboard();
    test_same_cycle();
    test_x0();
    test_clk_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
